axi4_stream_rr_arbiter: RTL and testbench
=========================================

Name: axi4_stream_rr_arbiter

Overview:
- N-to-1 AXI4-Stream packet arbiter. It shares one downstream stream (the receiver side of the std AXI4-Stream interface) among N_SOURCES senders.
- Arbitration is round-robin.
- A grant is held from the first beat of a packet until its tlast beat, so packets are never interleaved.
- The output passes through a registered skid stage. This gives full throughput and cuts the timing path from m_tready to the source tready signals.

Parameters:
- N_SOURCES, 4, number of upstream senders (2..16)
- DATA_WIDTH_BYTES, 4, tdata width in bytes; tkeep width equals DATA_WIDTH_BYTES
- ID_WIDTH, 4, tid width
- DEST_WIDTH, 4, tdest width
- SRC_WIDTH, $clog2(N_SOURCES), width of the source index fields

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_tvalid  in  N_SOURCES  per-source tvalid
- o_tready  out  N_SOURCES  per-source tready
- i_tdata  in  N_SOURCES*8*DATA_WIDTH_BYTES  packed per-source tdata; source k occupies slice k
- i_tkeep  in  N_SOURCES*DATA_WIDTH_BYTES  packed per-source tkeep
- i_tlast  in  N_SOURCES  per-source tlast
- i_tid  in  N_SOURCES*ID_WIDTH  packed per-source tid
- i_tdest  in  N_SOURCES*DEST_WIDTH  packed per-source tdest
- o_m_tvalid  out  1  downstream tvalid
- i_m_tready  in  1  downstream tready
- o_m_tdata  out  8*DATA_WIDTH_BYTES  downstream tdata
- o_m_tkeep  out  DATA_WIDTH_BYTES  downstream tkeep
- o_m_tlast  out  1  downstream tlast
- o_m_tid  out  ID_WIDTH  downstream tid, passed through from the source
- o_m_tdest  out  DEST_WIDTH  downstream tdest
- o_m_tsrc  out  SRC_WIDTH  index of the source that sent the current output beat
- o_busy  out  1  high while a packet is locked (state LOCKED)
- o_grant  out  SRC_WIDTH  currently locked source; holds the last granted source while IDLE

Behaviour:
- Reset is synchronous, active-high, on i_clk. While i_rst=1 at a clock edge:
  - state <= IDLE; last_grant <= N_SOURCES-1, so source 0 has first priority.
  - Skid stage is emptied: o_m_tvalid=0.
  - o_busy=0 and o_grant=N_SOURCES-1.
  - o_tready is forced to all-0 while i_rst is asserted.
  - Data outputs are don't-care but are driven to 0.
- Reset mid-packet abandons the packet. The partially forwarded beats are not completed and no tlast is synthesised.
- The skid stage (sub-module) has an input side with in_valid, in_ready and a payload, and an output side o_m_*.
  - in_ready = !skid_full.
  - Latency is exactly 1 cycle from source acceptance to o_m_tvalid.
  - Sustains 1 beat/cycle while i_m_tready=1.
  - When i_m_tready is deasserted, the output holds o_m_* stable until accepted (AXI rule). The second register absorbs one in-flight beat.
- Arbitration FSM has two states, IDLE and LOCKED.
  - IDLE:
    - sel = first k with i_tvalid[k]=1, searching from (last_grant+1) mod N_SOURCES upward with wrap.
    - o_tready[sel] = in_ready; all other o_tready bits are 0.
    - If no source is valid, all o_tready bits are 0 and the state holds.
    - A beat is accepted when i_tvalid[sel] & in_ready.
    - Accepted beat with tlast=1 (single-beat packet): stay IDLE, last_grant <= sel.
    - Accepted beat with tlast=0: go to LOCKED, lock <= sel, last_grant <= sel.
  - LOCKED:
    - o_tready[lock] = in_ready; all other o_tready bits are 0.
    - The lock holds regardless of i_tvalid[lock] going low mid-packet. There is no timeout.
    - Accepting a beat with tlast=1 returns to IDLE. The next arbitration happens in the following cycle, so there is one idle arbitration cycle per multi-beat packet.
- A sender that deasserts tvalid without a beat being accepted is legal and has no effect.
- o_grant = lock in LOCKED, last_grant in IDLE. o_busy = (state==LOCKED).
- o_m_tsrc carries sel (in IDLE) or lock (in LOCKED), registered together with the payload.
- Simultaneous requests resolve strictly by round-robin order. A sender that stays valid is served within N_SOURCES packets (no starvation).
- The combinational tready path is i_m_tready -> skid registers only. o_tready depends on registered state and the registered skid_full flag, plus i_tvalid in IDLE.

Decomposition:
- Shared package axi4_stream_arb_pkg:
  - state_t enum {IDLE, LOCKED}
  - beat_t packed struct {tdata, tkeep, tlast, tid, tdest, tsrc}, parameterised via the package parameters
  - function rr_pick(req, last) returning the round-robin index
- Sub-module axi4_stream_skid_buffer: a generic 2-entry valid/ready register slice carrying beat_t. It is reused elsewhere in the std stream path.

Test Plan:
- Reset then source 0 sends a 3-beat packet (tdata 0x11, 0x22, 0x33, tlast on beat 3) with i_m_tready=1:
  - o_m_tvalid rises 1 cycle after the first acceptance.
  - Beats arrive in order with o_m_tsrc=0.
  - o_busy=1 after beat 1 and 0 after beat 3.
- Sources 0, 1 and 3 all hold valid, each with 1-beat packets:
  - Output order is 0, 1, 3, 0, 1, 3.
  - Source 2 is never granted, and o_tready[2] is always 0.
- Source 1 is locked mid-packet and source 2 asserts valid:
  - Source 2 sees tready=0 until source 1's tlast is accepted.
  - Source 2 is granted in the next arbitration.
  - No beat interleaving appears on the output.
- Backpressure: i_m_tready held 0 for 5 cycles during a 4-beat burst:
  - o_m_* stays stable.
  - At most 2 beats are accepted upstream (skid full).
  - After release, all 4 beats arrive with no loss or duplication.
- Locked source drops tvalid for 3 cycles mid-packet:
  - The lock is held, other sources stay blocked, and the packet completes on resume.
- i_rst asserted for 1 cycle while LOCKED on source 2 with 2 beats buffered:
  - Next cycle o_m_tvalid=0, o_busy=0 and o_grant=N_SOURCES-1.
  - The next request from sources 0 and 2 is granted to 0.

Source files
------------

// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and the round-robin helper for the AXI4-Stream packet arbiter.
// Widths here define beat_t and must match the arbiter parameters.
package axi4_stream_arb_pkg;

  localparam int ARB_N_SOURCES        = 4;
  localparam int ARB_DATA_WIDTH_BYTES = 4;
  localparam int ARB_ID_WIDTH         = 4;
  localparam int ARB_DEST_WIDTH       = 4;
  localparam int ARB_SRC_WIDTH        = $clog2(ARB_N_SOURCES);
  localparam int ARB_DATA_WIDTH       = 8 * ARB_DATA_WIDTH_BYTES;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [ARB_DATA_WIDTH-1:0]       tdata;
    logic [ARB_DATA_WIDTH_BYTES-1:0] tkeep;
    logic                            tlast;
    logic [ARB_ID_WIDTH-1:0]         tid;
    logic [ARB_DEST_WIDTH-1:0]       tdest;
    logic [ARB_SRC_WIDTH-1:0]        tsrc;
  } beat_t;

  // First requester after 'last', wrapping; returns 'last' when nobody requests.
  function automatic logic [ARB_SRC_WIDTH-1:0] rr_pick(
    input logic [ARB_N_SOURCES-1:0] req,
    input logic [ARB_SRC_WIDTH-1:0] last
  );
    logic [ARB_SRC_WIDTH-1:0] pick;
    logic                     found;
    int                       idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= ARB_N_SOURCES; i++) begin
      idx = (int'(last) + i) % ARB_N_SOURCES;
      if (!found && req[idx[ARB_SRC_WIDTH-1:0]]) begin
        pick  = idx[ARB_SRC_WIDTH-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi4_stream_skid_buffer.sv
// Two-entry valid/ready register slice for beat_t: one output register plus a
// skid register that absorbs the beat in flight when the sink stalls.
module axi4_stream_skid_buffer
  import axi4_stream_arb_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_in_valid,
  output logic  o_in_ready,
  input  beat_t i_in_beat,
  output logic  o_out_valid,
  input  logic  i_out_ready,
  output beat_t o_out_beat
);

  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  beat_t out_beat_q, out_beat_d;
  beat_t skid_beat_q, skid_beat_d;
  logic  in_fire_s;
  logic  out_free_s;

  // Readiness only looks at the registered skid flag, never at i_out_ready.
  assign o_in_ready = !skid_valid_q;
  assign in_fire_s  = i_in_valid & !skid_valid_q;
  assign out_free_s = i_out_ready | !out_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    if (out_free_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire_s;
        if (in_fire_s) begin
          out_beat_d = i_in_beat;
        end else begin
          out_beat_d = out_beat_q;
        end
      end
    end else begin
      if (in_fire_s) begin
        skid_valid_d = 1'b1;
        skid_beat_d  = i_in_beat;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_beat_q   <= '0;
      skid_beat_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_beat_q   <= out_beat_d;
      skid_beat_q  <= skid_beat_d;
    end
  end

  assign o_out_valid = out_valid_q;
  assign o_out_beat  = out_beat_q;

endmodule

// File: rtl/axi4_stream_rr_arbiter.sv
// N-to-1 AXI4-Stream packet arbiter: round-robin choice between packets, grant
// locked until tlast, output registered through a skid slice.
module axi4_stream_rr_arbiter
  import axi4_stream_arb_pkg::*;
#(
  parameter int N_SOURCES        = ARB_N_SOURCES,
  parameter int DATA_WIDTH_BYTES = ARB_DATA_WIDTH_BYTES,
  parameter int ID_WIDTH         = ARB_ID_WIDTH,
  parameter int DEST_WIDTH       = ARB_DEST_WIDTH,
  parameter int SRC_WIDTH        = $clog2(N_SOURCES)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N_SOURCES-1:0]                  i_tvalid,
  output logic [N_SOURCES-1:0]                  o_tready,
  input  logic [N_SOURCES*8*DATA_WIDTH_BYTES-1:0] i_tdata,
  input  logic [N_SOURCES*DATA_WIDTH_BYTES-1:0] i_tkeep,
  input  logic [N_SOURCES-1:0]                  i_tlast,
  input  logic [N_SOURCES*ID_WIDTH-1:0]         i_tid,
  input  logic [N_SOURCES*DEST_WIDTH-1:0]       i_tdest,
  output logic                                  o_m_tvalid,
  input  logic                                  i_m_tready,
  output logic [8*DATA_WIDTH_BYTES-1:0]         o_m_tdata,
  output logic [DATA_WIDTH_BYTES-1:0]           o_m_tkeep,
  output logic                                  o_m_tlast,
  output logic [ID_WIDTH-1:0]                   o_m_tid,
  output logic [DEST_WIDTH-1:0]                 o_m_tdest,
  output logic [SRC_WIDTH-1:0]                  o_m_tsrc,
  output logic                                  o_busy,
  output logic [SRC_WIDTH-1:0]                  o_grant
);

  localparam int DW = 8 * DATA_WIDTH_BYTES;

  state_t               state_q, state_d;
  logic [SRC_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [SRC_WIDTH-1:0] lock_q, lock_d;
  logic [SRC_WIDTH-1:0] sel_s;
  logic [SRC_WIDTH-1:0] cur_s;
  logic                 any_valid_s;
  logic                 in_valid_s;
  logic                 in_ready_s;
  logic                 accept_s;
  beat_t                beat_s;
  beat_t                out_beat_s;

  assign sel_s       = rr_pick(i_tvalid, last_grant_q);
  assign any_valid_s = |i_tvalid;
  assign cur_s       = (state_q == LOCKED) ? lock_q : sel_s;
  assign accept_s    = in_valid_s & in_ready_s;

  // Mux the selected source's sideband into one beat, tagged with its index.
  always_comb begin
    beat_s = '0;
    for (int k = 0; k < N_SOURCES; k++) begin
      if (cur_s == SRC_WIDTH'(k)) begin
        beat_s.tdata = i_tdata[k*DW +: DW];
        beat_s.tkeep = i_tkeep[k*DATA_WIDTH_BYTES +: DATA_WIDTH_BYTES];
        beat_s.tlast = i_tlast[k];
        beat_s.tid   = i_tid[k*ID_WIDTH +: ID_WIDTH];
        beat_s.tdest = i_tdest[k*DEST_WIDTH +: DEST_WIDTH];
      end else begin
        beat_s = beat_s;
      end
    end
    beat_s.tsrc = cur_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_WIDTH'(N_SOURCES - 1);
      lock_q       <= SRC_WIDTH'(N_SOURCES - 1);
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          last_grant_d = sel_s;
          if (!beat_s.tlast) begin
            state_d = LOCKED;
            lock_d  = sel_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        // Lock survives tvalid gaps; only an accepted tlast releases it.
        if (accept_s && beat_s.tlast) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    o_tready   = '0;
    in_valid_s = 1'b0;
    if (i_rst) begin
      o_tready   = '0;
      in_valid_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid_s) begin
            o_tready[sel_s] = in_ready_s;
            in_valid_s      = i_tvalid[sel_s];
          end else begin
            in_valid_s = 1'b0;
          end
        end
        LOCKED: begin
          o_tready[lock_q] = in_ready_s;
          in_valid_s       = i_tvalid[lock_q];
        end
        default: begin
          in_valid_s = 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = (state_q == LOCKED);
  assign o_grant = (state_q == LOCKED) ? lock_q : last_grant_q;

  axi4_stream_skid_buffer u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (in_valid_s),
    .o_in_ready  (in_ready_s),
    .i_in_beat   (beat_s),
    .o_out_valid (o_m_tvalid),
    .i_out_ready (i_m_tready),
    .o_out_beat  (out_beat_s)
  );

  assign o_m_tdata = out_beat_s.tdata;
  assign o_m_tkeep = out_beat_s.tkeep;
  assign o_m_tlast = out_beat_s.tlast;
  assign o_m_tid   = out_beat_s.tid;
  assign o_m_tdest = out_beat_s.tdest;
  assign o_m_tsrc  = out_beat_s.tsrc;

endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Directed bench for axi4_stream_rr_arbiter: a vector table for reset, the
// first packet and round-robin order, then hand-written multi-cycle sequences.
module tb_axi4_stream_rr_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_tvalid;
  logic [3:0]  o_tready;
  logic [127:0] i_tdata;
  logic [15:0] i_tkeep;
  logic [3:0]  i_tlast;
  logic [15:0] i_tid;
  logic [15:0] i_tdest;
  logic        o_m_tvalid;
  logic        i_m_tready;
  logic [31:0] o_m_tdata;
  logic [3:0]  o_m_tkeep;
  logic        o_m_tlast;
  logic [3:0]  o_m_tid;
  logic [3:0]  o_m_tdest;
  logic [1:0]  o_m_tsrc;
  logic        o_busy;
  logic [1:0]  o_grant;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  axi4_stream_rr_arbiter dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tvalid   (i_tvalid),
    .o_tready   (o_tready),
    .i_tdata    (i_tdata),
    .i_tkeep    (i_tkeep),
    .i_tlast    (i_tlast),
    .i_tid      (i_tid),
    .i_tdest    (i_tdest),
    .o_m_tvalid (o_m_tvalid),
    .i_m_tready (i_m_tready),
    .o_m_tdata  (o_m_tdata),
    .o_m_tkeep  (o_m_tkeep),
    .o_m_tlast  (o_m_tlast),
    .o_m_tid    (o_m_tid),
    .o_m_tdest  (o_m_tdest),
    .o_m_tsrc   (o_m_tsrc),
    .o_busy     (o_busy),
    .o_grant    (o_grant)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } mon_t;

  mon_t mon_q[$];

  // Record every beat the downstream side accepts.
  always @(posedge i_clk) begin
    if (!i_rst && o_m_tvalid && i_m_tready) begin
      mon_q.push_back('{src: o_m_tsrc, data: o_m_tdata, last: o_m_tlast});
    end
  end

  typedef struct packed {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic [7:0] d;
    logic       mr;
    logic [3:0] e_rdy;
    logic       e_mv;
    logic [1:0] e_src;
    logic       e_busy;
    logic [1:0] e_grant;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source k carries tdata {k, 16'h0, d}, tid k, tdest k+8.
  task automatic apply(input logic rst, input logic [3:0] v, input logic [3:0] l,
                       input logic [7:0] d, input logic mr);
    @(negedge i_clk);
    i_rst      = rst;
    i_tvalid   = v;
    i_tlast    = l;
    i_m_tready = mr;
    for (int k = 0; k < 4; k++) begin
      i_tdata[k*32 +: 32] = {8'(k), 16'h0000, d};
      i_tkeep[k*4 +: 4]   = 4'hF;
      i_tid[k*4 +: 4]     = 4'(k);
      i_tdest[k*4 +: 4]   = 4'(k + 8);
    end
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_mon(input string name, input int idx, input logic [1:0] src,
                         input logic [7:0] d, input logic last);
    logic [31:0] exp_data;
    exp_data = {6'b000000, src, 16'h0000, d};
    if (idx < mon_q.size()) begin
      chk({name, "_src"}, 32'(mon_q[idx].src), 32'(src));
      chk({name, "_data"}, mon_q[idx].data, exp_data);
      chk({name, "_last"}, 32'(mon_q[idx].last), 32'(last));
    end else begin
      chk({name, "_present"}, 32'(mon_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   acc_by_stall_end;
    logic acc;
    logic mr;

    i_rst = 1'b1; i_tvalid = '0; i_tlast = '0; i_m_tready = 1'b1;
    i_tdata = '0; i_tkeep = '0; i_tid = '0; i_tdest = '0;

    //                rst   v        l        d      mr    e_rdy    mv    src   busy  grant
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd3};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 8'h11, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 8'h22, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 8'h33, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd3};
    tbl[6]  = '{1'b0, 4'b1011, 4'b1011, 8'h41, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
    tbl[7]  = '{1'b0, 4'b1011, 4'b1011, 8'h42, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 2'd1};
    tbl[8]  = '{1'b0, 4'b1011, 4'b1011, 8'h43, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 2'd3};
    tbl[9]  = '{1'b0, 4'b1011, 4'b1011, 8'h44, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 4'b1011, 4'b1011, 8'h45, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 2'd1};
    tbl[11] = '{1'b0, 4'b1011, 4'b1011, 8'h46, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 2'd3};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd3};

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].mr);
      chk($sformatf("row%0d_tready", i), 32'(o_tready), 32'(tbl[i].e_rdy));
      tick();
      chk($sformatf("row%0d_m_tvalid", i), 32'(o_m_tvalid), 32'(tbl[i].e_mv));
      chk($sformatf("row%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_grant", i), 32'(o_grant), 32'(tbl[i].e_grant));
      if (tbl[i].e_mv) begin
        chk($sformatf("row%0d_tsrc", i), 32'(o_m_tsrc), 32'(tbl[i].e_src));
        chk($sformatf("row%0d_tdata", i), o_m_tdata,
            {6'b000000, tbl[i].e_src, 16'h0000, tbl[i].d});
        chk($sformatf("row%0d_tid", i), 32'(o_m_tid), {30'd0, tbl[i].e_src});
        chk($sformatf("row%0d_tlast", i), 32'(o_m_tlast), 32'(tbl[i].l[tbl[i].e_src]));
      end
    end

    // Source 1 locked while source 2 waits.
    apply(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1); tick();
    mon_q.delete();
    apply(1'b0, 4'b0010, 4'b0000, 8'h51, 1'b1); chk("s3_rdy_first", 32'(o_tready), 32'h2); tick();
    apply(1'b0, 4'b0110, 4'b0100, 8'h52, 1'b1); chk("s3_blocked_a", 32'(o_tready), 32'h2); tick();
    apply(1'b0, 4'b0110, 4'b0110, 8'h53, 1'b1); chk("s3_blocked_b", 32'(o_tready), 32'h2); tick();
    apply(1'b0, 4'b0100, 4'b0100, 8'h54, 1'b1); chk("s3_grant2", 32'(o_tready), 32'h4); tick();
    apply(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1); tick(); tick();
    chk("s3_count", 32'(mon_q.size()), 32'd4);
    chk_mon("s3_b0", 0, 2'd1, 8'h51, 1'b0);
    chk_mon("s3_b1", 1, 2'd1, 8'h52, 1'b0);
    chk_mon("s3_b2", 2, 2'd1, 8'h53, 1'b1);
    chk_mon("s3_b3", 3, 2'd2, 8'h54, 1'b1);

    // Backpressure: 4-beat burst from source 0, sink stalls 5 cycles.
    apply(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1); tick();
    mon_q.delete();
    idx = 0;
    acc_by_stall_end = 0;
    for (int c = 0; c < 40 && !(idx == 4 && mon_q.size() >= 4); c++) begin
      mr = (c >= 1 && c <= 5) ? 1'b0 : 1'b1;
      apply(1'b0, (idx < 4) ? 4'b0001 : 4'b0000, (idx == 3) ? 4'b0001 : 4'b0000,
            8'h61 + 8'(idx), mr);
      if (c >= 1 && c <= 5) begin
        chk($sformatf("s4_hold_valid_c%0d", c), 32'(o_m_tvalid), 32'd1);
        chk($sformatf("s4_hold_data_c%0d", c), o_m_tdata, 32'h00000061);
      end
      acc = o_tready[0] & i_tvalid[0];
      tick();
      if (acc) idx++;
      if (c == 5) acc_by_stall_end = idx;
    end
    chk("s4_accepted_during_stall_le2", 32'(acc_by_stall_end <= 2), 32'd1);
    chk("s4_count", 32'(mon_q.size()), 32'd4);
    chk_mon("s4_b0", 0, 2'd0, 8'h61, 1'b0);
    chk_mon("s4_b1", 1, 2'd0, 8'h62, 1'b0);
    chk_mon("s4_b2", 2, 2'd0, 8'h63, 1'b0);
    chk_mon("s4_b3", 3, 2'd0, 8'h64, 1'b1);

    // Locked source 1 drops tvalid for 3 cycles while source 0 keeps requesting.
    apply(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1); tick();
    mon_q.delete();
    apply(1'b0, 4'b0010, 4'b0000, 8'h71, 1'b1); chk("s5_rdy_first", 32'(o_tready), 32'h2); tick();
    apply(1'b0, 4'b0011, 4'b0001, 8'h72, 1'b1); chk("s5_rdy_second", 32'(o_tready), 32'h2); tick();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 4'b0001, 4'b0001, 8'h00, 1'b1);
      chk($sformatf("s5_gap_tready_c%0d", c), 32'(o_tready), 32'h2);
      chk($sformatf("s5_gap_busy_c%0d", c), 32'(o_busy), 32'd1);
      chk($sformatf("s5_gap_grant_c%0d", c), 32'(o_grant), 32'd1);
      tick();
    end
    apply(1'b0, 4'b0011, 4'b0011, 8'h73, 1'b1); chk("s5_rdy_last", 32'(o_tready), 32'h2); tick();
    apply(1'b0, 4'b0001, 4'b0001, 8'h74, 1'b1); chk("s5_grant0", 32'(o_tready), 32'h1); tick();
    apply(1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1); tick(); tick();
    chk("s5_count", 32'(mon_q.size()), 32'd4);
    chk_mon("s5_b0", 0, 2'd1, 8'h71, 1'b0);
    chk_mon("s5_b1", 1, 2'd1, 8'h72, 1'b0);
    chk_mon("s5_b2", 2, 2'd1, 8'h73, 1'b1);
    chk_mon("s5_b3", 3, 2'd0, 8'h74, 1'b1);

    // Reset while locked on source 2 with two beats buffered.
    apply(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0); tick();
    mon_q.delete();
    apply(1'b0, 4'b0100, 4'b0000, 8'h81, 1'b0); chk("s6_rdy_a", 32'(o_tready), 32'h4); tick();
    apply(1'b0, 4'b0100, 4'b0000, 8'h82, 1'b0); chk("s6_rdy_b", 32'(o_tready), 32'h4); tick();
    chk("s6_busy_locked", 32'(o_busy), 32'd1);
    apply(1'b1, 4'b0100, 4'b0000, 8'h83, 1'b0); chk("s6_rdy_in_rst", 32'(o_tready), 32'h0); tick();
    chk("s6_m_tvalid", 32'(o_m_tvalid), 32'd0);
    chk("s6_busy", 32'(o_busy), 32'd0);
    chk("s6_grant", 32'(o_grant), 32'd3);
    apply(1'b0, 4'b0101, 4'b0101, 8'h84, 1'b1); chk("s6_next_grant", 32'(o_tready), 32'h1); tick();
    chk("s6_out_valid", 32'(o_m_tvalid), 32'd1);
    chk("s6_out_src", 32'(o_m_tsrc), 32'd0);
    chk("s6_out_data", o_m_tdata, 32'h00000084);
    chk("s6_no_stale_beats", 32'(mon_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
